// File: rtl/RV_32_consts.sv
// Shared RV32 constants: canonical NOP encoding and the preload FSM state type.
package RV_32_consts;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_e;

endpackage

// File: rtl/tb_constants.sv
// Platform sizing constants shared by the memory model and its environment.
package tb_constants;

  localparam int MEMORY_SIZE = 64;

endpackage

// File: rtl/rv32_mem_loader.sv
// Preload sequencer: accepts image beats into consecutive words, then hands the
// memory over to the core until the next reset.
module rv32_mem_loader
  import RV_32_consts::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic             run_o,
  output logic             load_we_o,
  output logic [IDX_W-1:0] load_idx_o
);

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] load_ptr_q, load_ptr_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    load_we_o  = 1'b0;
    if (state_q == LOAD && load_valid_i) begin
      load_we_o  = 1'b1;
      load_ptr_d = load_ptr_q + IDX_W'(1);
      // The last word of the array ends the load even without a last marker.
      if (load_last_i || load_ptr_q == IDX_W'(MEM_WORDS - 1)) begin
        state_d = RUN;
      end
    end
  end

  assign load_ready_o = (state_q == LOAD);
  assign run_o        = (state_q == RUN);
  assign load_idx_o   = load_ptr_q;

endmodule

// File: rtl/rv32_mem_responder.sv
// Unified instruction/data memory model for an RV32 core, preloaded over a
// beat interface and then serving one fetch and one data access per cycle.
module rv32_mem_responder
  import RV_32_consts::*;
#(
  parameter int MEM_WORDS = tb_constants::MEMORY_SIZE,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_addr_i,
  output logic [31:0]          instr_data_o,
  input  logic [31:0]          mem_addr_i,
  input  logic                 mem_we_i,
  input  logic [31:0]          mem_wdata_i,
  output logic [31:0]          mem_rdata_o,
  input  logic                 load_valid_i,
  input  logic [31:0]          load_data_i,
  input  logic                 load_last_i,
  output logic                 load_ready_o,
  output logic                 run_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} < MEM_BYTES) && (addr[1:0] == 2'b00);
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  logic             load_we;
  logic [IDX_W-1:0] load_idx;

  rv32_mem_loader #(
    .MEM_WORDS(MEM_WORDS),
    .IDX_W    (IDX_W)
  ) u_loader (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_valid_i(load_valid_i),
    .load_last_i (load_last_i),
    .load_ready_o(load_ready_o),
    .run_o       (run_o),
    .load_we_o   (load_we),
    .load_idx_o  (load_idx)
  );

  logic             i_ok, d_ok, run_we, mem_we;
  logic [IDX_W-1:0] i_idx, d_idx, mem_widx;
  logic [31:0]      mem_wdata;

  assign i_ok   = in_range(instr_addr_i);
  assign d_ok   = in_range(mem_addr_i);
  assign i_idx  = instr_addr_i[IDX_W+1:2];
  assign d_idx  = mem_addr_i[IDX_W+1:2];
  assign run_we = run_o && mem_we_i && d_ok;

  assign mem_we    = load_we || run_we;
  assign mem_widx  = run_o ? d_idx : load_idx;
  assign mem_wdata = run_o ? mem_wdata_i : load_data_i;

  // NOTE: storage has no reset; contents must survive a reset mid-load.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  logic [31:0]          instr_data_q, instr_data_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]           err_inc;
  logic [ERR_CNT_W:0]   err_sum;

  always_comb begin
    instr_data_d = NOP_INSTR;
    mem_rdata_d  = '0;
    err_inc      = 2'd0;
    if (run_o) begin
      // Fetch sees pre-write contents; the data port forwards its own write.
      if (i_ok) instr_data_d = mem_q[i_idx];
      if (run_we) mem_rdata_d = mem_wdata_i;
      else if (d_ok) mem_rdata_d = mem_q[d_idx];
      err_inc = {1'b0, !i_ok} + {1'b0, !d_ok};
    end
    err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_inc);
    err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    err_d     = err_q || (err_inc != 2'd0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_data_q <= NOP_INSTR;
      mem_rdata_q  <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      instr_data_q <= instr_data_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign instr_data_o = instr_data_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign err_o        = err_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Directed bench for rv32_mem_responder: preload, data/fetch ports, error
// counting and saturation, reset during load, and load cut-off at full memory.
module tb_rv32_mem_responder;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] OOR       = 32'h0000_0100;  // MEM_WORDS*4

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic [31:0] instr_data_o;
  logic [31:0] mem_addr_i = '0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        load_valid_i = 1'b0;
  logic [31:0] load_data_i = '0;
  logic        load_last_i = 1'b0;
  logic        load_ready_o;
  logic        run_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  rv32_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .ERR_CNT_W(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_addr_i(instr_addr_i),
    .instr_data_o(instr_data_o),
    .mem_addr_i  (mem_addr_i),
    .mem_we_i    (mem_we_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .load_valid_i(load_valid_i),
    .load_data_i (load_data_i),
    .load_last_i (load_last_i),
    .load_ready_o(load_ready_o),
    .run_o       (run_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    load_valid_i = 1'b1;
    load_data_i  = data;
    load_last_i  = last;
    step();
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    instr_addr_i = addr;
    step();
    check(tag, instr_data_o, exp);
  endtask

  initial begin
    // Reset state
    step();
    check("rst_instr", instr_data_o, NOP);
    check("rst_rdata", mem_rdata_o, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_cnt", {24'b0, err_cnt_o}, 32'h0);
    rst_i = 1'b1;
    #1;
    check("rel_ready", {31'b0, load_ready_o}, 32'h1);
    check("rel_run", {31'b0, run_o}, 32'h0);

    // Three-beat preload ending on last
    beat(32'h0050_0093, 1'b0);
    check("load_run_early", {31'b0, run_o}, 32'h0);
    beat(32'h00A0_0113, 1'b0);
    beat(32'h0000_0013, 1'b1);
    check("load_run", {31'b0, run_o}, 32'h1);
    check("load_ready_low", {31'b0, load_ready_o}, 32'h0);
    check("load_instr_nop", instr_data_o, NOP);
    fetch("fetch0", 32'h0, 32'h0050_0093);
    fetch("fetch4", 32'h4, 32'h00A0_0113);
    fetch("fetch8", 32'h8, 32'h0000_0013);
    check("no_err_yet", {24'b0, err_cnt_o}, 32'h0);

    // Data write then read; same-cycle write-first
    instr_addr_i = 32'h0;
    mem_addr_i   = 32'h10;
    mem_we_i     = 1'b1;
    mem_wdata_i  = 32'hDEAD_BEEF;
    step();
    mem_we_i = 1'b0;
    step();
    check("rd_after_wr", mem_rdata_o, 32'hDEAD_BEEF);
    mem_we_i    = 1'b1;
    mem_wdata_i = 32'h1234_5678;
    step();
    check("wr_first", mem_rdata_o, 32'h1234_5678);
    mem_we_i = 1'b0;
    step();
    check("rd_stored", mem_rdata_o, 32'h1234_5678);

    // Fetch of the word being written returns old contents
    instr_addr_i = 32'h10;
    mem_we_i     = 1'b1;
    mem_wdata_i  = 32'hCAFE_F00D;
    step();
    check("fetch_old", instr_data_o, 32'h1234_5678);
    check("rd_fwd", mem_rdata_o, 32'hCAFE_F00D);
    mem_we_i = 1'b0;
    step();
    check("fetch_new", instr_data_o, 32'hCAFE_F00D);

    // Out-of-range fetch, then bad fetch plus bad write in one cycle
    mem_addr_i = 32'h0;
    fetch("oor_fetch", OOR, NOP);
    check("oor_err", {31'b0, err_o}, 32'h1);
    check("oor_cnt1", {24'b0, err_cnt_o}, 32'h1);
    mem_addr_i  = OOR + 32'h4;
    mem_we_i    = 1'b1;
    mem_wdata_i = 32'h5555_5555;
    step();
    check("oor_cnt3", {24'b0, err_cnt_o}, 32'h3);
    check("oor_wr_rdata", mem_rdata_o, 32'h0);
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h4;
    fetch("oor_wr_dropped", 32'h4, 32'h00A0_0113);
    check("oor_wr_dropped_rd", mem_rdata_o, 32'h00A0_0113);
    check("oor_cnt_hold", {24'b0, err_cnt_o}, 32'h3);

    // Misaligned data read
    mem_addr_i = 32'h6;
    step();
    check("misalign_rd", mem_rdata_o, 32'h0);
    check("misalign_cnt", {24'b0, err_cnt_o}, 32'h4);
    mem_addr_i = 32'h0;

    // Saturation: 4 + 250 = 254, then 50 more must stop at 255
    instr_addr_i = OOR;
    for (int i = 0; i < 250; i++) step();
    check("sat_254", {24'b0, err_cnt_o}, 32'hFE);
    for (int i = 0; i < 50; i++) step();
    check("sat_255", {24'b0, err_cnt_o}, 32'hFF);
    step();
    check("sat_hold", {24'b0, err_cnt_o}, 32'hFF);
    instr_addr_i = 32'h0;

    // Reset after 2 of 4 beats, then a single-beat reload
    rst_i = 1'b0;
    #1;
    check("rst2_cnt", {24'b0, err_cnt_o}, 32'h0);
    check("rst2_ready", {31'b0, load_ready_o}, 32'h1);
    rst_i = 1'b1;
    beat(32'h1111_1111, 1'b0);
    beat(32'h2222_2222, 1'b0);
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    beat(32'h9999_9999, 1'b1);
    check("reload_run", {31'b0, run_o}, 32'h1);
    fetch("reload_w0", 32'h0, 32'h9999_9999);
    fetch("reload_w1", 32'h4, 32'h2222_2222);
    fetch("reload_w2", 32'h8, 32'h0000_0013);
    check("reload_err", {31'b0, err_o}, 32'h0);
    check("reload_cnt", {24'b0, err_cnt_o}, 32'h0);

    // Full-memory load stops on the last word without a last marker
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < MEM_WORDS - 1; i++) beat(32'hA000_0000 + 32'(i), 1'b0);
    check("full_not_run", {31'b0, run_o}, 32'h0);
    beat(32'hA000_003F, 1'b0);
    check("full_run", {31'b0, run_o}, 32'h1);
    beat(32'hBBBB_BBBB, 1'b0);
    fetch("full_last_word", 32'hFC, 32'hA000_003F);
    fetch("run_ignores_load", 32'h0, 32'hA000_0000);
    check("full_cnt", {24'b0, err_cnt_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
